// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8 columns.
// The shift is applied on the input side, and a 2-entry skid buffer keeps in_ready registered.
module shift_rows_pipe #(
   parameter int NB = 4,
   parameter int W  = 32 * NB
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   if (W != 32 * NB) begin : g_bad_w
      $error("shift_rows_pipe: W must equal 32*NB");
   end

   logic [W-1:0] shifted;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         main_v;
   logic         skid_v;
   logic         accept;
   logic         pop;

   // Byte (r,c) sits at bit W-1-8*(4c+r); both source columns are elaboration constants.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SH  = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int FWD = (c + SH) % NB;
         localparam int INV = (c + NB - SH) % NB;
         assign shifted[W-1-8*(4*c+r) -: 8] = in_inv ? in_data[W-1-8*(4*INV+r) -: 8]
                                                     : in_data[W-1-8*(4*FWD+r) -: 8];
      end
   end

   assign in_ready  = ~skid_v & ~rst;
   assign accept    = in_valid & in_ready;
   assign pop       = main_v & out_ready;
   assign out_valid = main_v;
   assign out_data  = main_q;

   // The skid entry is always older than any new input, so it refills main first.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (!main_v || pop) begin
         if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            if (accept) begin
               skid_q <= shifted;
               skid_v <= 1'b1;
            end else begin
               skid_v <= 1'b0;
            end
         end else if (accept) begin
            main_q <= shifted;
            main_v <= 1'b1;
            skid_v <= 1'b0;
         end else begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= shifted;
         skid_v <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4 and NB=8 instances, directed vectors, queue-based scoreboard.
module tb_shift_rows_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
   logic [127:0] in_data4, out_data4;
   logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
   logic [255:0] in_data8, out_data8;

   int tests = 0;
   int fails = 0;

   logic [127:0] exp4_q[$];
   logic [255:0] exp8_q[$];

   localparam logic [127:0] A  = 128'h632d6323630953fcf4a751ca6363ca8c;
   localparam logic [127:0] RA = 128'h6309518c63a7ca23f46363fc632d53ca;
   localparam logic [127:0] B  = 128'hfe71189cdee0bbfaddd7340cd3d8f5fd;
   localparam logic [127:0] RB = 128'hfee034fdded7f59cddd818fad371bb0c;
   localparam logic [255:0] V8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] R8 = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

   shift_rows_pipe #(.NB(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .in_inv    (in_inv4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4)
   );

   shift_rows_pipe #(.NB(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_data   (in_data8),
      .in_inv    (in_inv8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_data  (out_data8)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: pop and compare whenever a result is handed off.
   always @(negedge clk) begin
      if (!rst && out_valid4 && out_ready4) begin
         if (exp4_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL nb4_unexpected: got %h expected nothing", out_data4);
         end else begin
            check("nb4_out", {128'h0, out_data4}, {128'h0, exp4_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid8 && out_ready8) begin
         if (exp8_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL nb8_unexpected: got %h expected nothing", out_data8);
         end else begin
            check("nb8_out", out_data8, exp8_q.pop_front());
         end
      end
   end

   task automatic send4(input logic [127:0] d, input logic inv, input logic [127:0] exp);
      int waited;
      waited = 0;
      in_valid4 = 1'b1;
      in_data4  = d;
      in_inv4   = inv;
      @(negedge clk);
      while (!in_ready4 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready4) begin
         tests++;
         fails++;
         $display("FAIL nb4_accept_timeout: in_ready %b expected 1", in_ready4);
      end else begin
         exp4_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      in_data4  = {$urandom, $urandom, $urandom, $urandom};
      in_inv4   = 1'($urandom_range(0, 1));
   endtask

   task automatic send8(input logic [255:0] d, input logic inv, input logic [255:0] exp);
      int waited;
      waited = 0;
      in_valid8 = 1'b1;
      in_data8  = d;
      in_inv8   = inv;
      @(negedge clk);
      while (!in_ready8 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready8) begin
         tests++;
         fails++;
         $display("FAIL nb8_accept_timeout: in_ready %b expected 1", in_ready8);
      end else begin
         exp8_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      in_data8  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_inv8   = 1'($urandom_range(0, 1));
   endtask

   initial begin
      logic [127:0] alt_in;
      logic [127:0] alt_exp;
      logic         alt_inv;
      int           waited;

      rst        = 1'b1;
      in_valid4  = 1'b0;
      in_data4   = '0;
      in_inv4    = 1'b0;
      out_ready4 = 1'b1;
      in_valid8  = 1'b0;
      in_data8   = '0;
      in_inv8    = 1'b0;
      out_ready8 = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_in_ready4", {255'h0, in_ready4}, 256'h0);
      check("rst_in_ready8", {255'h0, in_ready8}, 256'h0);
      @(posedge clk);
      #1;
      check("rst_out_valid4", {255'h0, out_valid4}, 256'h0);
      check("rst_out_data4", {128'h0, out_data4}, 256'h0);
      check("rst_out_valid8", {255'h0, out_valid8}, 256'h0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready4", {255'h0, in_ready4}, 256'h1);

      // Forward, back-to-back, one-cycle latency
      send4(A, 1'b0, RA);
      check("fwd_a_valid", {255'h0, out_valid4}, 256'h1);
      check("fwd_a_data", {128'h0, out_data4}, {128'h0, RA});
      send4(B, 1'b0, RB);
      check("fwd_b_valid", {255'h0, out_valid4}, 256'h1);
      check("fwd_b_data", {128'h0, out_data4}, {128'h0, RB});

      // Inverse
      send4(RA, 1'b1, A);
      check("inv_a_data", {128'h0, out_data4}, {128'h0, A});

      // Alternating modes, each input the previous output, no bubbles
      alt_in = A;
      for (int i = 0; i < 6; i++) begin
         alt_inv = 1'(i % 2);
         alt_exp = alt_inv ? A : RA;
         send4(alt_in, alt_inv, alt_exp);
         check("alt_valid", {255'h0, out_valid4}, 256'h1);
         check("alt_data", {128'h0, out_data4}, {128'h0, alt_exp});
         alt_in = alt_exp;
      end

      // NB=8 forward and inverse
      send8(V8, 1'b0, R8);
      check("nb8_fwd_data", out_data8, R8);
      send8(R8, 1'b1, V8);
      check("nb8_inv_data", out_data8, V8);

      // Backpressure: A, B fill main and skid, C must wait
      repeat (3) @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      send4(A, 1'b0, RA);
      send4(B, 1'b0, RB);
      in_valid4 = 1'b1;
      in_data4  = RA;
      in_inv4   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", {255'h0, in_ready4}, 256'h0);
         check("bp_stall_valid", {255'h0, out_valid4}, 256'h1);
         check("bp_stall_data", {128'h0, out_data4}, {128'h0, RA});
      end
      @(posedge clk);
      #1;
      out_ready4 = 1'b1;
      send4(RA, 1'b1, A);
      repeat (4) @(posedge clk);
      #1;

      // Reset with main and skid both full
      out_ready4 = 1'b0;
      send4(A, 1'b0, RA);
      send4(B, 1'b0, RB);
      rst       = 1'b1;
      in_valid4 = 1'b1;
      in_data4  = B;
      in_inv4   = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {255'h0, in_ready4}, 256'h0);
      @(posedge clk);
      #1;
      exp4_q.delete();
      check("mid_rst_out_valid", {255'h0, out_valid4}, 256'h0);
      check("mid_rst_out_data", {128'h0, out_data4}, 256'h0);
      check("mid_rst_in_ready_held", {255'h0, in_ready4}, 256'h0);
      rst        = 1'b0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      #1;
      check("after_rst_in_ready", {255'h0, in_ready4}, 256'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("after_rst_no_output", {255'h0, out_valid4}, 256'h0);
      end

      // Drain
      waited = 0;
      while ((exp4_q.size() != 0 || exp8_q.size() != 0) && waited < 50) begin
         @(posedge clk);
         waited++;
      end
      @(negedge clk);
      check("nb4_leftover", 256'(exp4_q.size()), 256'h0);
      check("nb8_leftover", 256'(exp8_q.size()), 256'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Registered, flow-controlled ShiftRows / InvShiftRows stage for the encryption and decryption datapaths.
- Generalised to Rijndael block widths Nb = 4, 6 or 8 columns, i.e. 128, 192 or 256 bits; AES-128 uses Nb = 4.
- Direction (forward or inverse) is selected per transaction.
- Valid/ready handshake with a 2-entry skid buffer: full throughput under backpressure, no combinational ready path from output to input.

Parameters:
- NB, 4, number of state columns; legal values are 4, 6 and 8. Any other value must cause an elaboration error.
- W, 32*NB, state width in bits (derived; not to be overridden).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_inv are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  W  input state.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  W  shifted state.

Behaviour:
- Byte mapping: s(r,c) = in_data[W-1-8*(4c+r) -: 8], for r = 0..3 and c = 0..NB-1 (column-major, MSB first). out_data uses the same mapping.
- Row offsets sh(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out(r,c) = s(r, (c + sh(r)) mod NB).
- Inverse: out(r,c) = s(r, (c - sh(r)) mod NB).
- The shift is computed combinationally on the input side. Registered content is the already-shifted state; no mode bit is stored.
- Storage: main register (main_q, main_v) drives out_data/out_valid; skid register (skid_q, skid_v).
- in_ready = ~skid_v & ~rst.
- Input handshake: accept = in_valid & in_ready. Output handshake: pop = out_valid & out_ready.
- Per-cycle update, in priority order:
  - rst: main_v = 0, skid_v = 0, main_q = 0, skid_q = 0. Inputs are ignored.
  - main empty, or pop: main loads skid_q if skid_v; else the shifted input if accept; else main_v = 0. If main loaded from skid and accept, skid loads the shifted input; otherwise skid_v = 0.
  - main full and no pop: if accept, skid loads the shifted input and skid_v = 1. (accept cannot occur when skid_v = 1.)
- Latency: 1 cycle from accept to out_valid when main is empty or popping.
- Throughput: 1 state per cycle while out_ready = 1.
- Ordering: strict FIFO; at most 2 states held.
- Stability: out_data and out_valid must not change while out_valid = 1 and out_ready = 0.
- Reset values: out_valid = 0, out_data = 0; in_ready = 0 during rst and 1 in the first cycle after rst deasserts.
- Reset mid-operation: all held states are discarded with no output; the accept in the reset cycle is dropped.
- in_data/in_inv while in_valid = 0, or while in_ready = 0, are don't-care and must have no effect.
- Mixed in_inv across consecutive transactions is legal; each result uses its own mode.

Test Plan:
- NB=4, in_inv=0, out_ready=1:
  - in_data 632d6323630953fcf4a751ca6363ca8c -> out_data 6309518c63a7ca23f46363fc632d53ca one cycle later.
  - Next cycle, in_data fe71189cdee0bbfaddd7340cd3d8f5fd -> fee034fdded7f59cddd818fad371bb0c; back-to-back out_valid.
- NB=4, in_inv=1: in_data 6309518c63a7ca23f46363fc632d53ca -> 632d6323630953fcf4a751ca6363ca8c.
- NB=4, forward then inverse alternating on consecutive cycles, each input the same as the previous output -> the original state returns; no bubbles.
- NB=8, in_inv=0, in_data 000102...1f (byte k = k):
  - -> 00050e13040912170 80d161b0c111a1f10151e031419020718 1d060b1c010a0f, i.e. 00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f.
  - Same vector with in_inv=1 on that output -> 000102...1f.
- Backpressure, NB=4: out_ready=0 with three valid inputs A, B, C on consecutive cycles:
  - A and B are accepted; in_ready=0 on C's cycle.
  - out_data stays at A's result while stalled.
  - Raise out_ready: A, B, C results emerge in order; C is accepted once in_ready=1.
- Reset mid-operation: main and skid full, assert rst for one cycle:
  - out_valid=0, out_data=0, in_ready=0 during rst.
  - in_ready=1 the next cycle; no stale result ever appears.
